// File: rtl/dig_pkg.sv
// Shared constants for the 8-digit seven-segment display: bus address,
// segment codes and the digit-select helper.
package dig_pkg;

  localparam logic [31:0] DIG_ADDR_DEF = 32'hFFFF_F000;

  localparam int unsigned DISP_W = 32;
  localparam int unsigned DIG_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;

  // Active-low segment codes {G,F,E,D,C,B,A} for hex digits 0..F
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  localparam logic [DIG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [DIG_W-1:0] DIG_OFF   = 8'hFF;

  typedef logic [2:0] dig_idx_t;

  // One-hot-low anode enable for the selected digit
  function automatic logic [DIG_W-1:0] anode_sel(input dig_idx_t idx);
    return ~(DIG_W'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
  import dig_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK[SEG_W-1:0];
    case (i_nibble)
      4'h0: o_seg_c = SEG_0;
      4'h1: o_seg_c = SEG_1;
      4'h2: o_seg_c = SEG_2;
      4'h3: o_seg_c = SEG_3;
      4'h4: o_seg_c = SEG_4;
      4'h5: o_seg_c = SEG_5;
      4'h6: o_seg_c = SEG_6;
      4'h7: o_seg_c = SEG_7;
      4'h8: o_seg_c = SEG_8;
      4'h9: o_seg_c = SEG_9;
      4'hA: o_seg_c = SEG_A;
      4'hB: o_seg_c = SEG_B;
      4'hC: o_seg_c = SEG_C;
      4'hD: o_seg_c = SEG_D;
      4'hE: o_seg_c = SEG_E;
      4'hF: o_seg_c = SEG_F;
      default: o_seg_c = SEG_BLANK[SEG_W-1:0];
    endcase
  end

endmodule

// File: rtl/dig_display.sv
// Memory-mapped 8-digit multiplexed seven-segment display driver.
// A bus write loads eight hex nibbles; the scanner lights one digit at a time.
module dig_display
  import dig_pkg::*;
#(
  parameter logic [31:0] DIG_ADDR = DIG_ADDR_DEF,
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [DISP_W-1:0] wdata,
  output logic [DIG_W-1:0]  dig_en,
  output logic [DIG_W-1:0]  seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [DISP_W-1:0] r_disp;
  logic [CNT_W-1:0]  r_cnt;
  dig_idx_t          r_idx;

  logic              w_wrap;
  logic              w_wr_hit;
  logic [NIB_W-1:0]  w_nibble;
  logic [SEG_W-1:0]  w_seg;

  assign w_wrap   = (r_cnt == CNT_MAX);
  assign w_wr_hit = we && (addr == DIG_ADDR);
  assign w_nibble = r_disp[{r_idx, 2'b00} +: NIB_W];

  seg7_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg)
  );

  // Anode and segments both derive from the same registered idx/disp,
  // so they always switch together and never mix old and new nibbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      dig_en <= DIG_OFF;
      seg    <= SEG_BLANK;
    end else begin
      if (w_wr_hit) begin
        r_disp <= wdata;
      end
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) begin
        r_idx <= r_idx + 3'd1;
      end
      dig_en <= anode_sel(r_idx);
      seg    <= {1'b1, w_seg};
    end
  end

endmodule

// File: doc/dig_display.md
DIG_DISPLAY -- requirements
Module: dig_display

Interface
REQ-001 Parameter DIG_ADDR, default 32'hFFFF_F000, bus address of the display data register.
REQ-002 Parameter SCAN_DIV, default 20000, clk cycles each digit stays lit; legal range 2..2^20.
REQ-003 clk  input  1  system clock, single clock domain, all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 addr  input  32  bus address from the bus bridge.
REQ-006 we  input  1  write enable, already qualified by the bridge's address decode.
REQ-007 wdata  input  32  write data, eight 4-bit hex digits, wdata[3:0] = rightmost digit.
REQ-008 dig_en  output  8  digit anode enables, active-low, one-hot-low while scanning.
REQ-009 seg  output  8  segment cathodes {DP,G,F,E,D,C,B,A}, active-low.

Function
REQ-010 Display register disp[31:0]: loaded with wdata on a clk edge where we=1 and addr==DIG_ADDR; otherwise holds.
REQ-011 Write with we=1 and addr!=DIG_ADDR: disp unchanged.
REQ-012 Prescaler cnt: 0..SCAN_DIV-1, increments every cycle, wraps to 0 after SCAN_DIV-1.
REQ-013 Digit index idx[2:0]: increments by 1 on the cycle cnt wraps; idx 7 -> 0.
REQ-014 dig_en registered: dig_en = ~(8'b1 << idx) one cycle after idx updates; exactly one bit low outside reset.
REQ-015 seg registered, same cycle as dig_en: encodes nibble disp[4*idx+3 : 4*idx] with the hex table below; DP (seg[7]) always 1 (off).
REQ-016 Hex table, seg[6:0] active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-017 dig_en and seg change on the same clk edge; no cycle with the new anode and the old segment pattern.
REQ-018 Write latency: new disp value appears on seg at the next digit refresh, no later than SCAN_DIV+1 cycles after the write edge for the digit currently selected.
REQ-019 Write on the same edge as an idx change: the new idx uses the new disp value one cycle later; no partial-nibble mixing.
REQ-020 Back-to-back writes: last write wins; each write is one-cycle and needs no handshake.
REQ-021 Block never drives read data; reads of DIG_ADDR are handled by the bridge.

Reset
REQ-022 rst=0 on a clk edge: disp=0, cnt=0, idx=0, dig_en=8'hFF (all off), seg=8'hFF (all off).
REQ-023 First edge with rst=1: cnt counts from 0. dig_en=8'hFE and seg shows disp[3:0] from the following cycle.
REQ-024 Reset asserted mid-scan or mid-write: takes priority over the write; all REQ-022 values apply on that edge.

Structure
REQ-025 Shared package dig_pkg holds DIG_ADDR default, segment-code constants for 0..F, and the blank code 8'hFF.
REQ-026 Sub-module seg7_decoder: purely combinational, 4-bit nibble in, 7-bit active-low segments out, implements REQ-016.
REQ-027 Top holds disp, cnt, idx and the output registers. No other sub-modules.

Verification (SCAN_DIV=4)
REQ-028 Reset held 3 cycles then released -> dig_en=FF and seg=FF during reset; dig_en=FE, seg=C0 ('0') from cycle 2 after release.
REQ-029 Write 32'h8765_4321 to DIG_ADDR, observe 32 cycles -> dig_en steps FE,FD,FB,...,7F, each held 4 cycles; seg shows 79,24,30,19,12,02,78,00 (DP bit 1).
REQ-030 Write 32'hDEAD_BEEF with addr=32'hFFFF_F060 -> disp stays at its prior value, seg unchanged.
REQ-031 Write 32'hFFFF_FFFF exactly on an idx-wrap edge -> next displayed digit is 8E, with no glitch cycle between dig_en and seg.
REQ-032 Pull rst=0 during a write cycle with idx=5 -> same edge gives disp=0, dig_en=FF, seg=FF; scanning restarts at idx 0.
REQ-033 Two consecutive writes 0x1, then 0x2 -> digit 0 shows 24 ('2'); 79 ('1') never appears on digit 0 after the second write.
